sdr_init_ref_seq: RTL and testbench

- SDRAM power-up initialisation sequencer and periodic auto-refresh scheduler for the sdr_ctrl core.
- Drives the SDRAM command bus while it owns it: during init, and during each granted refresh slot.
- Requests the bus from the transfer controller with a req/gnt handshake.
- Runs in the sdram_clk domain, beside the Wishbone-to-SDRAM request path.

---
 rtl/sdr_seq_pkg.sv | 40 ++++
 rtl/sdr_ref_timer.sv | 50 +++++
 rtl/sdr_init_ref_seq.sv | 201 ++++++++++++++++++++
 tb/tb_sdr_init_ref_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_seq_pkg.sv
// Shared definitions for the SDRAM init/refresh sequencer: command encodings,
// FSM state type and timer sizing helper.
package sdr_seq_pkg;

    // Commands encoded as {ras_n, cas_n, we_n}; issued with cs_n = 0
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_AR  = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;

    typedef enum logic [3:0] {
        RST_WAIT,
        INIT_PRE,
        INIT_TRP,
        INIT_AR,
        INIT_TRFC,
        INIT_MRS,
        INIT_TMRD,
        IDLE,
        REQ,
        REF_PRE,
        REF_TRP,
        REF_AR,
        REF_TRFC
    } seq_state_e;

    // Width of a down-counter able to hold the largest of the timing values
    function automatic int unsigned tmr_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sdr_ref_timer.sv
// Refresh-credit generator: interval counter plus saturating pending-credit
// counter. credit_c flags the cycle in which a credit is being added.
module sdr_ref_timer #(
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned MAX_PEND     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dec,
    output logic [3:0] ref_pend,
    output logic       urgent,
    output logic       credit_c
);

    localparam int unsigned IW = (REF_INTERVAL < 2) ? 1 : $clog2(REF_INTERVAL);

    logic [IW-1:0] ivl_cnt;
    logic          wrap;

    assign wrap     = en && (ivl_cnt == IW'(REF_INTERVAL - 1));
    assign credit_c = wrap;

    // Interval counter, held at zero while credit generation is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ivl_cnt <= '0;
        end else if (!en || wrap) begin
            ivl_cnt <= '0;
        end else begin
            ivl_cnt <= ivl_cnt + IW'(1);
        end
    end

    // Pending credits; simultaneous credit and service cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_pend <= '0;
            urgent   <= 1'b0;
        end else begin
            if (wrap && !dec) begin
                if (ref_pend != 4'(MAX_PEND)) ref_pend <= ref_pend + 4'd1;
            end else if (dec && !wrap) begin
                if (ref_pend != 4'd0) ref_pend <= ref_pend - 4'd1;
            end
            urgent <= (ref_pend == 4'(MAX_PEND));
        end
    end

endmodule

// File: rtl/sdr_init_ref_seq.sv
// SDRAM power-up init sequencer and auto-refresh scheduler.
// Optional macro SDR_REF_BURST_EN: one grant drains every pending credit.
module sdr_init_ref_seq
    import sdr_seq_pkg::*;
#(
    parameter int unsigned INIT_WAIT    = 10000,
    parameter int unsigned T_RP         = 3,
    parameter int unsigned T_RFC        = 7,
    parameter int unsigned T_MRD        = 2,
    parameter int unsigned NUM_INIT_REF = 2,
    parameter int unsigned REF_INTERVAL = 780,
    parameter int unsigned MAX_PEND     = 8,
    parameter int unsigned AW           = 13
) (
    input  logic          sdram_clk,
    input  logic          sdram_resetn,
    input  logic [AW-1:0] cfg_mode_reg,
    input  logic          cfg_ref_en,
    input  logic          ref_gnt,
    output logic          ref_req,
    output logic          ref_urgent,
    output logic          seq_active,
    output logic          init_done,
    output logic          sdr_cke,
    output logic          sdr_cs_n,
    output logic          sdr_ras_n,
    output logic          sdr_cas_n,
    output logic          sdr_we_n,
    output logic [1:0]    sdr_ba,
    output logic [AW-1:0] sdr_addr,
    output logic [3:0]    ref_pend
);

    localparam int unsigned TW  = tmr_width(INIT_WAIT, T_RP, T_RFC, T_MRD);
    localparam int unsigned ARW = (NUM_INIT_REF < 2) ? 1 : $clog2(NUM_INIT_REF + 1);
    // Wait states last T-1 cycles so the next command lands exactly at n+T
    localparam int unsigned TRP_LD  = (T_RP  >= 2) ? T_RP  - 2 : 0;
    localparam int unsigned TRFC_LD = (T_RFC >= 2) ? T_RFC - 2 : 0;
    localparam int unsigned TMRD_LD = (T_MRD >= 2) ? T_MRD - 2 : 0;

    seq_state_e     state, state_next;
    logic [TW-1:0]  tmr, tmr_next;
    logic [ARW-1:0] ar_cnt, ar_cnt_next;
    logic           tmr_zero;
    logic           credit_c;
    logic           dec_c;
    logic           pend_avail_c;

    logic [2:0]     cmd_next;
    logic [AW-1:0]  addr_next;
    logic           act_next;

    // Refresh credit bookkeeping
    sdr_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL),
        .MAX_PEND     (MAX_PEND)
    ) u_ref_timer (
        .clk      (sdram_clk),
        .rst_n    (sdram_resetn),
        .en       (init_done && cfg_ref_en),
        .dec      (dec_c),
        .ref_pend (ref_pend),
        .urgent   (ref_urgent),
        .credit_c (credit_c)
    );

    assign tmr_zero     = (tmr == '0);
    assign pend_avail_c = (ref_pend != 4'd0) || credit_c;
    assign dec_c        = (state_next == REF_AR);

    // State register with timing counter and init AR count
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state  <= RST_WAIT;
            tmr    <= TW'(INIT_WAIT);
            ar_cnt <= '0;
        end else begin
            state  <= state_next;
            tmr    <= tmr_next;
            ar_cnt <= ar_cnt_next;
        end
    end

    // Next-state logic and next command decode
    always_comb begin
        state_next  = state;
        tmr_next    = tmr;
        ar_cnt_next = ar_cnt;
        cmd_next    = CMD_NOP;
        addr_next   = '0;
        act_next    = 1'b1;

        case (state)
            RST_WAIT: begin
                if (tmr_zero) state_next = INIT_PRE;
                else          tmr_next   = tmr - TW'(1);
            end
            INIT_PRE: begin
                state_next = INIT_TRP;
                tmr_next   = TW'(TRP_LD);
            end
            INIT_TRP: begin
                if (tmr_zero) state_next = INIT_AR;
                else          tmr_next   = tmr - TW'(1);
            end
            INIT_AR: begin
                state_next  = INIT_TRFC;
                tmr_next    = TW'(TRFC_LD);
                ar_cnt_next = ar_cnt + ARW'(1);
            end
            INIT_TRFC: begin
                if (tmr_zero) begin
                    if (ar_cnt == ARW'(NUM_INIT_REF)) state_next = INIT_MRS;
                    else                              state_next = INIT_AR;
                end else begin
                    tmr_next = tmr - TW'(1);
                end
            end
            INIT_MRS: begin
                state_next = INIT_TMRD;
                tmr_next   = TW'(TMRD_LD);
            end
            INIT_TMRD: begin
                if (tmr_zero) state_next = IDLE;
                else          tmr_next   = tmr - TW'(1);
            end
            IDLE: begin
                if (pend_avail_c) state_next = REQ;
            end
            REQ: begin
                if (ref_gnt) state_next = REF_PRE;
            end
            REF_PRE: begin
                state_next = REF_TRP;
                tmr_next   = TW'(TRP_LD);
            end
            REF_TRP: begin
                if (tmr_zero) state_next = REF_AR;
                else          tmr_next   = tmr - TW'(1);
            end
            REF_AR: begin
                state_next = REF_TRFC;
                tmr_next   = TW'(TRFC_LD);
            end
            REF_TRFC: begin
                if (tmr_zero) begin
`ifdef SDR_REF_BURST_EN
                    if (pend_avail_c) state_next = REF_AR;
                    else              state_next = IDLE;
`else
                    state_next = IDLE;
`endif
                end else begin
                    tmr_next = tmr - TW'(1);
                end
            end
            default: state_next = RST_WAIT;
        endcase

        case (state_next)
            INIT_PRE, REF_PRE: begin
                cmd_next      = CMD_PRE;
                addr_next[10] = 1'b1;
            end
            INIT_AR, REF_AR: cmd_next = CMD_AR;
            INIT_MRS: begin
                cmd_next  = CMD_MRS;
                addr_next = cfg_mode_reg;
            end
            default: cmd_next = CMD_NOP;
        endcase

        act_next = !(state_next inside {IDLE, REQ});
    end

    // Registered command bus and status outputs
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            sdr_cke    <= 1'b0;
            sdr_cs_n   <= 1'b1;
            sdr_ras_n  <= 1'b1;
            sdr_cas_n  <= 1'b1;
            sdr_we_n   <= 1'b1;
            sdr_ba     <= 2'b00;
            sdr_addr   <= '0;
            ref_req    <= 1'b0;
            seq_active <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            sdr_cke    <= 1'b1;
            sdr_cs_n   <= !act_next;
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_next;
            sdr_ba     <= 2'b00;
            sdr_addr   <= addr_next;
            ref_req    <= (state_next == REQ);
            seq_active <= act_next;
            init_done  <= init_done || (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_sdr_init_ref_seq.sv
// Bench for sdr_init_ref_seq: expected commands (cycle, opcode, address) are
// queued ahead of time and matched as the DUT puts them on the bus.
module tb_sdr_init_ref_seq;
    import sdr_seq_pkg::*;

    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cfg_mode_reg;
    logic          cfg_ref_en;
    logic          ref_gnt;
    logic          ref_req, ref_urgent, seq_active, init_done;
    logic          sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [1:0]    sdr_ba;
    logic [AW-1:0] sdr_addr;
    logic [3:0]    ref_pend;

    typedef struct {
        int            cyc;
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [AW-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   base = 0;
    int   rst_cyc;

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sdr_init_ref_seq #(
        .INIT_WAIT    (20),
        .T_RP         (2),
        .T_RFC        (6),
        .T_MRD        (2),
        .NUM_INIT_REF (2),
        .REF_INTERVAL (50),
        .MAX_PEND     (4),
        .AW           (AW)
    ) dut (
        .sdram_clk    (clk),
        .sdram_resetn (rst_n),
        .cfg_mode_reg (cfg_mode_reg),
        .cfg_ref_en   (cfg_ref_en),
        .ref_gnt      (ref_gnt),
        .ref_req      (ref_req),
        .ref_urgent   (ref_urgent),
        .seq_active   (seq_active),
        .init_done    (init_done),
        .sdr_cke      (sdr_cke),
        .sdr_cs_n     (sdr_cs_n),
        .sdr_ras_n    (sdr_ras_n),
        .sdr_cas_n    (sdr_cas_n),
        .sdr_we_n     (sdr_we_n),
        .sdr_ba       (sdr_ba),
        .sdr_addr     (sdr_addr),
        .ref_pend     (ref_pend)
    );

    function automatic int cur_cyc();
        return edge_cnt - base;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cur_cyc(), obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [2:0] cmd,
                        input logic [AW-1:0] a, input logic [AW-1:0] m);
        exp_t e;
        e.cyc  = c;
        e.cmd  = cmd;
        e.addr = a;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cur_cyc() < n) @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_cke"},   int'(sdr_cke), 0);
        check({tag, "_cs_n"},  int'(sdr_cs_n), 1);
        check({tag, "_rcw"},   int'({sdr_ras_n, sdr_cas_n, sdr_we_n}), 7);
        check({tag, "_ba_addr"}, int'({sdr_ba, sdr_addr}), 0);
        check({tag, "_flags"}, int'({ref_req, ref_urgent, seq_active, init_done}), 4'b0010);
        check({tag, "_pend"},  int'(ref_pend), 0);
    endtask

    // Release reset at a falling edge and queue the full init command list
    task automatic release_reset();
        rst_n = 1'b1;
        base  = edge_cnt + 1;
        push(20, CMD_PRE, 13'h0400, 13'h0400);
        push(22, CMD_AR,  13'h0000, 13'h0000);
        push(28, CMD_AR,  13'h0000, 13'h0000);
        push(34, CMD_MRS, 13'h0033, 13'h1fff);
    endtask

    // Command monitor: every non-NOP command must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && !sdr_cs_n && ({sdr_ras_n, sdr_cas_n, sdr_we_n} != CMD_NOP)) begin
            if (sb.size() == 0) begin
                check("spurious_cmd", int'({sdr_ras_n, sdr_cas_n, sdr_we_n}), int'(CMD_NOP));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cmd_op",   int'({sdr_ras_n, sdr_cas_n, sdr_we_n}), int'(e.cmd));
                check("cmd_cyc",  cur_cyc(), e.cyc);
                check("cmd_addr", int'(sdr_addr & e.mask), int'(e.addr & e.mask));
                if (e.cmd == CMD_MRS) check("mrs_ba", int'(sdr_ba), 0);
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        ref_gnt      = 1'b0;
        cfg_ref_en   = 1'b1;
        cfg_mode_reg = 13'h0033;
        repeat (3) @(negedge clk);
        reset_checks("rst");

        // Init sequence with grant tied high
        release_reset();
        ref_gnt = 1'b1;
        wait_cyc(0);
        check("cke_c0", int'(sdr_cke), 1);
        check("act_c0", int'({seq_active, sdr_cs_n}), 2'b10);
        wait_cyc(35);
        check("init_done_35", int'(init_done), 0);
        wait_cyc(36);
        check("init_done_36", int'({init_done, seq_active}), 2'b10);

        // First refresh, granted immediately
        push(87, CMD_PRE, 13'h0400, 13'h0400);
        push(89, CMD_AR,  13'h0000, 13'h0000);
        wait_cyc(85);
        check("req_85", int'({ref_req, ref_pend}), 5'h00);
        wait_cyc(86);
        check("req_86", int'({ref_req, ref_pend}), 5'h11);
        wait_cyc(87);
        check("gnt_87", int'({ref_req, seq_active}), 2'b01);
        wait_cyc(89);
        check("pend_89", int'(ref_pend), 0);
        wait_cyc(94);
        check("act_94", int'(seq_active), 1);
        wait_cyc(95);
        check("act_95", int'({seq_active, ref_req}), 0);

        // Withhold grant and let credits accumulate
        wait_cyc(100);
        ref_gnt = 1'b0;
        wait_cyc(136);
        check("req_136", int'({ref_req, ref_pend}), 5'h11);
        wait_cyc(236);
        check("pend_236", int'(ref_pend), 3);

`ifdef SDR_REF_BURST_EN
        // One grant drains all three credits
        push(241, CMD_PRE, 13'h0400, 13'h0400);
        push(243, CMD_AR,  13'h0000, 13'h0000);
        push(249, CMD_AR,  13'h0000, 13'h0000);
        push(255, CMD_AR,  13'h0000, 13'h0000);
        wait_cyc(240);
        ref_gnt = 1'b1;
        wait_cyc(241);
        ref_gnt = 1'b0;
        wait_cyc(249);
        check("burst_pend_249", int'(ref_pend), 1);
        wait_cyc(255);
        check("burst_pend_255", int'(ref_pend), 0);
        wait_cyc(260);
        check("burst_act_260", int'(seq_active), 1);
        wait_cyc(261);
        check("burst_act_261", int'({seq_active, ref_req}), 0);
        rst_cyc = 258;
`else
        // Saturation and urgency
        wait_cyc(286);
        check("pend_286", int'({ref_urgent, ref_pend}), 5'h04);
        wait_cyc(287);
        check("urgent_287", int'(ref_urgent), 1);
        wait_cyc(336);
        check("pend_sat_336", int'(ref_pend), 4);
        wait_cyc(340);
        check("req_hold_340", int'(ref_req), 1);

        // Single grant services exactly one credit
        push(351, CMD_PRE, 13'h0400, 13'h0400);
        push(353, CMD_AR,  13'h0000, 13'h0000);
        wait_cyc(350);
        ref_gnt = 1'b1;
        wait_cyc(351);
        ref_gnt = 1'b0;
        wait_cyc(352);
        check("pend_352", int'(ref_pend), 4);
        wait_cyc(353);
        check("pend_353", int'({ref_urgent, ref_pend}), 5'h13);
        wait_cyc(354);
        check("urgent_354", int'(ref_urgent), 0);
        wait_cyc(359);
        check("idle_359", int'({ref_req, seq_active}), 0);
        wait_cyc(360);
        check("rereq_360", int'(ref_req), 1);

        // Service lands in the same cycle as a new credit
        push(384, CMD_PRE, 13'h0400, 13'h0400);
        push(386, CMD_AR,  13'h0000, 13'h0000);
        wait_cyc(383);
        ref_gnt = 1'b1;
        wait_cyc(384);
        ref_gnt = 1'b0;
        wait_cyc(385);
        check("pend_385", int'(ref_pend), 3);
        wait_cyc(386);
        check("pend_coinc_386", int'(ref_pend), 3);
        rst_cyc = 388;
`endif

        // Reset during the post-refresh wait, then full init replay
        wait_cyc(rst_cyc);
        check("sb_drained", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        reset_checks("rst_mid");
        sb.delete();
        repeat (2) @(negedge clk);
        reset_checks("rst_hold");
        release_reset();
        wait_cyc(0);
        check("replay_cke", int'(sdr_cke), 1);
        wait_cyc(35);
        check("replay_done_35", int'(init_done), 0);
        wait_cyc(36);
        check("replay_done_36", int'({init_done, seq_active, ref_pend}), 6'h20);
        wait_cyc(40);
        check("replay_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
